rcc_int_div: RTL and testbench

Parametrised integer clock divider for the RCC. It generates o_clk at i_clk/N for any N from 1 to 2^RATIO_WID and a one-cycle-per-period enable pulse. The ratio changes at run time through a valid/ready request that takes effect only at an output period boundary, so o_clk never glitches. It replaces the fixed 1/2/4/8/16 divider wherever software-programmable arbitrary ratios are needed.

---
 rtl/rcc_int_div.sv | 96 +++++++++
 tb/tb_rcc_int_div.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rcc_int_div.sv
// Integer clock divider: o_clk = i_clk/N, N = 1..2^RATIO_WID, ratio changeable at run time.
// Latency: an accepted ratio is applied at the next output period boundary; chg_done follows one cycle later.
// Backpressure: req_ready drops while a ratio change is pending or reset is high.
module rcc_int_div #(
  parameter int RATIO_WID = 4,
  parameter int RST_RATIO = 1
) (
  input  logic                 i_clk,
  input  logic                 rst,
  input  logic [RATIO_WID-1:0] req_ratio,
  input  logic                 req_valid,
  output logic                 req_ready,
  output logic                 chg_done,
  output logic [RATIO_WID-1:0] cur_ratio,
  input  logic                 testmode,
  output logic                 div_en,
  output logic                 o_clk
);

  localparam logic [RATIO_WID-1:0] ONE      = RATIO_WID'(1);
  localparam logic [RATIO_WID-1:0] RST_ENC  = RATIO_WID'(RST_RATIO);
  localparam logic [RATIO_WID-1:0] RST_NM1  = RST_ENC - ONE;
  localparam logic                 RST_BYP  = (RST_ENC == ONE);
  localparam logic [RATIO_WID-1:0] HALF_MAX = ONE << (RATIO_WID - 1);

  // Number of high cycles per period, ceil(N/2). Encoded 0 stands for N = 2^RATIO_WID.
  function automatic logic [RATIO_WID-1:0] ceil_half(input logic [RATIO_WID-1:0] r);
    if (r == '0) begin
      return HALF_MAX;
    end
    return (r >> 1) + RATIO_WID'(r[0]);
  endfunction

  logic [RATIO_WID-1:0] cnt_q, cnt_d;
  logic [RATIO_WID-1:0] cur_ratio_q, cur_ratio_d;
  logic [RATIO_WID-1:0] pend_ratio_q, pend_ratio_d;
  logic                 pend_q, pend_d;
  logic                 o_clk_q, o_clk_d;
  logic                 bypass_q, bypass_d;
  logic                 chg_done_q;
  logic [RATIO_WID-1:0] nm1;
  logic                 wrap;
  logic                 accept;
  logic                 apply;

  // Next-state: phase counter, pending-ratio capture and boundary-aligned ratio switch.
  // N-1 wraps naturally to all-ones for the encoded-0 ratio.
  always_comb begin
    nm1          = cur_ratio_q - ONE;
    wrap         = (cnt_q == nm1);
    accept       = req_valid && req_ready;
    apply        = wrap && pend_q;
    cur_ratio_d  = apply ? pend_ratio_q : cur_ratio_q;
    cnt_d        = wrap ? '0 : cnt_q + ONE;
    o_clk_d      = (cnt_d < ceil_half(cur_ratio_d));
    bypass_d     = apply ? (pend_ratio_q == ONE) : bypass_q;
    pend_ratio_d = accept ? req_ratio : pend_ratio_q;
    pend_d       = pend_q;
    if (apply) begin
      pend_d = 1'b0;
    end else if (accept) begin
      pend_d = 1'b1;
    end
  end

  // State registers; reset parks the counter on the last phase so the first edge after release starts a period.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      cnt_q        <= RST_NM1;
      cur_ratio_q  <= RST_ENC;
      pend_ratio_q <= RST_ENC;
      pend_q       <= 1'b0;
      o_clk_q      <= 1'b0;
      bypass_q     <= RST_BYP;
      chg_done_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      cur_ratio_q  <= cur_ratio_d;
      pend_ratio_q <= pend_ratio_d;
      pend_q       <= pend_d;
      o_clk_q      <= o_clk_d;
      bypass_q     <= bypass_d;
      chg_done_q   <= apply;
    end
  end

  // Outputs: the bypass select only moves on a rising i_clk edge where o_clk_q also goes high, so the mux cannot runt.
  always_comb begin
    req_ready = !pend_q && !rst;
    chg_done  = chg_done_q;
    cur_ratio = cur_ratio_q;
    div_en    = !rst && (testmode || wrap);
    o_clk     = (testmode || bypass_q) ? i_clk : o_clk_q;
  end

endmodule

// File: tb/tb_rcc_int_div.sv
// Bench for rcc_int_div: hand-computed per-cycle expectations queued by the stimulus, checked by a monitor.
// Latency: expectations describe the cycle right after the stimulus edge.
// Backpressure: the stimulus follows req_ready by construction of the directed sequence.
`timescale 1ns/1ps
module tb_rcc_int_div;

  typedef struct packed {
    logic       ohi;
    logic       olo;
    logic       den;
    logic       chg;
    logic [3:0] ratio;
    logic       rdy;
  } exp_t;

  logic       i_clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_ratio = 4'd0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       chg_done;
  logic [3:0] cur_ratio;
  logic       testmode = 1'b0;
  logic       div_en;
  logic       o_clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  bit   gl_en = 1'b0;
  realtime last_t = 0.0;

  rcc_int_div #(.RATIO_WID(4), .RST_RATIO(1)) dut (
    .i_clk     (i_clk),
    .rst       (rst),
    .req_ratio (req_ratio),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .chg_done  (chg_done),
    .cur_ratio (cur_ratio),
    .testmode  (testmode),
    .div_en    (div_en),
    .o_clk     (o_clk)
  );

  always #5 i_clk = ~i_clk;

  // Monitor: samples o_clk in both i_clk phases and pops one expectation per cycle.
  initial begin
    logic hi;
    exp_t e, a;
    forever begin
      @(posedge i_clk);
      #2;
      hi = o_clk;
      @(negedge i_clk);
      #1;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        a = '{ohi: hi, olo: o_clk, den: div_en, chg: chg_done, ratio: cur_ratio, rdy: req_ready};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle_chk @%0t: got ohi=%b olo=%b den=%b chg=%b ratio=%0d rdy=%b, want ohi=%b olo=%b den=%b chg=%b ratio=%0d rdy=%b",
                   $time, a.ohi, a.olo, a.den, a.chg, a.ratio, a.rdy, e.ohi, e.olo, e.den, e.chg, e.ratio, e.rdy);
        end
      end
    end
  end

  // Glitch monitor: no o_clk pulse may be shorter than one i_clk phase.
  always @(o_clk) begin
    if (gl_en) begin
      checks++;
      if ($realtime - last_t < 5.0) begin
        errors++;
        $display("FAIL glitch @%0t: pulse width %0f ns, want >= 5 ns", $time, $realtime - last_t);
      end
    end
    last_t = $realtime;
  end

  task automatic tick(input logic ohi, input logic olo, input logic den, input logic chg,
                      input logic [3:0] r, input logic rdy);
    exp_t e;
    e = '{ohi: ohi, olo: olo, den: den, chg: chg, ratio: r, rdy: rdy};
    sbq.push_back(e);
    @(posedge i_clk);
    #1;
  endtask

  // One full divided period: hi cycles high then lo cycles low, div_en on the last cycle.
  task automatic period(input int hi, input int lo, input logic [3:0] r, input logic chg1, input logic rdy);
    for (int i = 0; i < hi + lo; i++) begin
      tick(i < hi, i < hi, i == hi + lo - 1, chg1 && (i == 0), r, rdy);
    end
  endtask

  initial begin
    @(posedge i_clk);
    #1;
    // 1: reset state, then N=1 bypass after release
    tick(1, 0, 0, 0, 4'd1, 0);
    tick(1, 0, 0, 0, 4'd1, 0);
    rst = 1'b0;
    tick(1, 0, 1, 0, 4'd1, 1);
    tick(1, 0, 1, 0, 4'd1, 1);
    gl_en = 1'b1;
    tick(1, 0, 1, 0, 4'd1, 1);

    // 2: request N=4 from bypass
    req_valid = 1'b1; req_ratio = 4'd4;
    tick(1, 0, 1, 0, 4'd1, 1);
    req_valid = 1'b0;
    tick(1, 0, 1, 0, 4'd1, 0);
    period(2, 2, 4'd4, 1, 1);
    period(2, 2, 4'd4, 0, 1);
    period(2, 2, 4'd4, 0, 1);

    // 3: request 5, then 3 with valid held
    req_valid = 1'b1; req_ratio = 4'd5;
    tick(1, 1, 0, 0, 4'd4, 1);
    req_ratio = 4'd3;
    tick(1, 1, 0, 0, 4'd4, 0);
    tick(0, 0, 0, 0, 4'd4, 0);
    tick(0, 0, 1, 0, 4'd4, 0);
    tick(1, 1, 0, 1, 4'd5, 1);
    req_valid = 1'b0;
    tick(1, 1, 0, 0, 4'd5, 0);
    tick(1, 1, 0, 0, 4'd5, 0);
    tick(0, 0, 0, 0, 4'd5, 0);
    tick(0, 0, 1, 0, 4'd5, 0);
    period(2, 1, 4'd3, 1, 1);
    period(2, 1, 4'd3, 0, 1);

    // 4: N=16 (encoded 0), then back to bypass
    req_valid = 1'b1; req_ratio = 4'd0;
    tick(1, 1, 0, 0, 4'd3, 1);
    req_valid = 1'b0;
    tick(1, 1, 0, 0, 4'd3, 0);
    tick(0, 0, 1, 0, 4'd3, 0);
    period(8, 8, 4'd0, 1, 1);
    req_valid = 1'b1; req_ratio = 4'd1;
    tick(1, 1, 0, 0, 4'd0, 1);
    req_valid = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick(i < 8, i < 8, i == 15, 0, 4'd0, 0);
    end
    tick(1, 0, 1, 1, 4'd1, 1);
    tick(1, 0, 1, 0, 4'd1, 1);

    // 5: N=2, same-value request accepted on the boundary edge
    req_valid = 1'b1; req_ratio = 4'd2;
    tick(1, 0, 1, 0, 4'd1, 1);
    req_valid = 1'b0;
    tick(1, 0, 1, 0, 4'd1, 0);
    tick(1, 1, 0, 1, 4'd2, 1);
    req_valid = 1'b1;
    tick(0, 0, 1, 0, 4'd2, 1);
    req_valid = 1'b0;
    tick(1, 1, 0, 0, 4'd2, 0);
    tick(0, 0, 1, 0, 4'd2, 0);
    tick(1, 1, 0, 1, 4'd2, 1);
    tick(0, 0, 1, 0, 4'd2, 1);

    // 6a: reset with a request pending at N=8, cnt=3
    gl_en = 1'b0;
    req_valid = 1'b1; req_ratio = 4'd8;
    tick(1, 1, 0, 0, 4'd2, 1);
    req_valid = 1'b0;
    tick(0, 0, 1, 0, 4'd2, 0);
    req_valid = 1'b1; req_ratio = 4'd6;
    tick(1, 1, 0, 1, 4'd8, 1);
    req_valid = 1'b0;
    tick(1, 1, 0, 0, 4'd8, 0);
    tick(1, 1, 0, 0, 4'd8, 0);
    rst = 1'b1;
    tick(1, 1, 0, 0, 4'd8, 0);
    tick(1, 0, 0, 0, 4'd1, 0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1, 0, 1, 0, 4'd1, 1);
    end

    // 6b: testmode during N=4, phase resumes afterwards
    req_valid = 1'b1; req_ratio = 4'd4;
    tick(1, 0, 1, 0, 4'd1, 1);
    req_valid = 1'b0;
    tick(1, 0, 1, 0, 4'd1, 0);
    tick(1, 1, 0, 1, 4'd4, 1);
    testmode = 1'b1;
    tick(1, 0, 1, 0, 4'd4, 1);
    tick(1, 0, 1, 0, 4'd4, 1);
    tick(1, 0, 1, 0, 4'd4, 1);
    tick(1, 0, 1, 0, 4'd4, 1);
    testmode = 1'b0;
    tick(1, 1, 0, 0, 4'd4, 1);
    tick(0, 0, 0, 0, 4'd4, 1);
    tick(0, 0, 1, 0, 4'd4, 1);
    period(2, 2, 4'd4, 0, 1);

    repeat (2) @(posedge i_clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expectations left, want 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
